// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment driver: sequential double-dabble BCD conversion plus glyph/message mode.
// Optional macro SSD_BRIGHTNESS_EN adds a 4-bit PWM brightness input gating the anode enables.
module ssd_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int VALUE_W    = 16,
  parameter int SCAN_DIV   = 17
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [VALUE_W-1:0]      value,
  input  logic                    load,
  output logic                    busy,
  output logic                    ovf,
  input  logic                    blank_en,
  input  logic                    msg_en,
  input  logic [5*NUM_DIGITS-1:0] msg,
`ifdef SSD_BRIGHTNESS_EN
  input  logic [3:0]              brightness,
`endif
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              ssd_out
);

  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCR_DIGITS = (NUM_DIGITS > (VALUE_W + 2) / 3) ? NUM_DIGITS : (VALUE_W + 2) / 3;
  localparam int SCR_W      = 4 * SCR_DIGITS;
  localparam int CNT_W      = $clog2(VALUE_W + 1);
  localparam int DSP_W      = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  conv_state_t          state_r;
  logic [VALUE_W-1:0]   bin_r;
  logic [SCR_W-1:0]     scr_r;
  logic [SCR_W-1:0]     adj_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [DSP_W-1:0]     bcd_r;
  logic                 ovf_s;
  logic [SCAN_DIV-1:0]  pre_r;
  logic [IDX_W-1:0]     idx_r;
  logic                 started_r;
  logic                 lead_zero_s;
  logic [4:0]           glyph_s;
  logic                 bright_on_s;
  logic [NUM_DIGITS-1:0] anode_s;

  function automatic logic [SCR_W-1:0] dabble_adjust(input logic [SCR_W-1:0] bcd);
    logic [SCR_W-1:0] res;
    res = bcd;
    for (int i = 0; i < SCR_DIGITS; i++) begin
      if (res[4*i +: 4] >= 4'd5) res[4*i +: 4] = res[4*i +: 4] + 4'd3;
      else                       res[4*i +: 4] = res[4*i +: 4];
    end
    return res;
  endfunction

  function automatic logic [6:0] glyph_seg(input logic [4:0] g);
    logic [6:0] seg;
    case (g)
      5'd0:    seg = 7'b0000001;
      5'd1:    seg = 7'b1001111;
      5'd2:    seg = 7'b0010010;
      5'd3:    seg = 7'b0000110;
      5'd4:    seg = 7'b1001100;
      5'd5:    seg = 7'b0100100;
      5'd6:    seg = 7'b0100000;
      5'd7:    seg = 7'b0001111;
      5'd8:    seg = 7'b0000000;
      5'd9:    seg = 7'b0000100;
      5'd10:   seg = 7'b1000100;
      5'd11:   seg = 7'b0001000;
      5'd12:   seg = 7'b1110001;
      5'd13:   seg = 7'b0000001;
      5'd14:   seg = 7'b0100100;
      5'd15:   seg = 7'b0110000;
      5'd16:   seg = 7'b1111110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Overflow: any converted nibble beyond the displayed digits is nonzero
  always_comb begin
    adj_s = dabble_adjust(scr_r);
    ovf_s = 1'b0;
    for (int j = NUM_DIGITS; j < SCR_DIGITS; j++) begin
      if (scr_r[4*j +: 4] != 4'd0) ovf_s = 1'b1;
      else                         ovf_s = ovf_s;
    end
  end

  // Conversion FSM; display BCD only changes in DONE so the scan never tears
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      ovf     <= 1'b0;
      bin_r   <= '0;
      scr_r   <= '0;
      cnt_r   <= '0;
      bcd_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load) begin
            bin_r   <= value;
            scr_r   <= '0;
            cnt_r   <= '0;
            busy    <= 1'b1;
            state_r <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scr_r <= {adj_s[SCR_W-2:0], bin_r[VALUE_W-1]};
          bin_r <= {bin_r[VALUE_W-2:0], 1'b0};
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(VALUE_W - 1)) state_r <= ST_DONE;
        end
        ST_DONE: begin
          bcd_r   <= scr_r[DSP_W-1:0];
          ovf     <= ovf_s;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Scan prescaler and digit index; the first slot after reset is a blank slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_r     <= '0;
      idx_r     <= '0;
      started_r <= 1'b0;
    end else begin
      pre_r <= pre_r + SCAN_DIV'(1);
      if (pre_r == '1) begin
        if (!started_r)                             started_r <= 1'b1;
        else if (idx_r == IDX_W'(NUM_DIGITS - 1))   idx_r     <= '0;
        else                                        idx_r     <= idx_r + IDX_W'(1);
      end
    end
  end

`ifdef SSD_BRIGHTNESS_EN
  assign bright_on_s = (pre_r[SCAN_DIV-1 -: 4] < brightness);
`else
  assign bright_on_s = 1'b1;
`endif

  // Glyph selection: a digit is a leading zero when it and everything above it is zero
  always_comb begin
    lead_zero_s = (idx_r != '0);
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((IDX_W'(j) >= idx_r) && (bcd_r[4*j +: 4] != 4'd0)) lead_zero_s = 1'b0;
      else                                                   lead_zero_s = lead_zero_s;
    end
    if (msg_en)                       glyph_s = msg[5*idx_r +: 5];
    else if (ovf)                     glyph_s = 5'd16;
    else if (blank_en && lead_zero_s) glyph_s = 5'd17;
    else                              glyph_s = {1'b0, bcd_r[4*idx_r +: 4]};
    anode_s        = '1;
    anode_s[idx_r] = ~bright_on_s;
  end

  // Registered pin drivers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode   <= '1;
      ssd_out <= 7'h7F;
    end else if (!started_r) begin
      anode   <= '1;
      ssd_out <= 7'h7F;
    end else begin
      anode   <= anode_s;
      ssd_out <= glyph_seg(glyph_s);
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: an 8-digit and a 4-digit instance (SCAN_DIV=4) against a decimal
// arithmetic model of the expected digit, glyph and anode for every scan cycle.
module tb_ssd_scan_driver;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'd0;
  logic        load = 1'b0;
  logic        blank_en = 1'b0;
  logic        msg_en = 1'b0;
  logic [39:0] msg_v = 40'd0;
  logic        busy8, ovf8, busy4, ovf4;
  logic [7:0]  anode8;
  logic [3:0]  anode4;
  logic [6:0]  ssd8, ssd4;
`ifdef SSD_BRIGHTNESS_EN
  logic [3:0]  brightness = 4'd15;
`endif
  int checks = 0;
  int fails = 0;
  int cyc;
  int shown8 = 0;
  int shown4 = 0;

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  ssd_scan_driver #(.NUM_DIGITS(8), .VALUE_W(16), .SCAN_DIV(4)) dut8 (
    .clk(clk), .reset(reset), .value(value), .load(load), .busy(busy8), .ovf(ovf8),
    .blank_en(blank_en), .msg_en(msg_en), .msg(msg_v),
`ifdef SSD_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .anode(anode8), .ssd_out(ssd8));

  ssd_scan_driver #(.NUM_DIGITS(4), .VALUE_W(16), .SCAN_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .value(value), .load(load), .busy(busy4), .ovf(ovf4),
    .blank_en(blank_en), .msg_en(msg_en), .msg(msg_v[19:0]),
`ifdef SSD_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .anode(anode4), .ssd_out(ssd4));

  function automatic logic [6:0] seg_of(int g);
    case (g)
      0: return 7'b0000001;   1: return 7'b1001111;   2: return 7'b0010010;
      3: return 7'b0000110;   4: return 7'b1001100;   5: return 7'b0100100;
      6: return 7'b0100000;   7: return 7'b0001111;   8: return 7'b0000000;
      9: return 7'b0000100;  10: return 7'b1000100;  11: return 7'b0001000;
      12: return 7'b1110001; 13: return 7'b0000001;  14: return 7'b0100100;
      15: return 7'b0110000; 16: return 7'b1111110;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int digit_idx(int nd, int n);
    return ((n - 1) / 16 - 1) % nd;
  endfunction

  function automatic int glyph_of(int nd, int v, int idx);
    longint p = 1;
    longint q = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    for (int i = 0; i < idx; i++) q = q * 10;
    if (msg_en) return int'(msg_v[5*idx +: 5]);
    if (v >= p) return 16;
    if (blank_en && idx != 0 && v < q) return 17;
    return int'((v / q) % 10);
  endfunction

  function automatic logic [7:0] exp_an(int nd, int n);
    logic [7:0] a = 8'hFF;
    if (n > 16) a[digit_idx(nd, n)] = 1'b0;
    return a;
  endfunction

  function automatic logic [6:0] exp_ssd(int nd, int n);
    if (n <= 16) return 7'h7F;
    return seg_of(glyph_of(nd, (nd == 8) ? shown8 : shown4, digit_idx(nd, n)));
  endfunction

  task automatic pulse_load(input int v);
    @(negedge clk);
    value = 16'(v);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (anode8 !== 8'hFF || ssd8 !== 7'h7F || busy8 !== 1'b0 || ovf8 !== 1'b0 || anode4 !== 4'hF) begin
      fails++;
      $display("FAIL reset_state got an=%h ssd=%b busy=%b ovf=%b an4=%h want FF 1111111 0 0 F",
               anode8, ssd8, busy8, ovf8, anode4);
    end
    reset = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      checks++;
      if (anode8 !== exp_an(8, cyc) || ssd8 !== exp_ssd(8, cyc)) begin
        fails++;
        $display("FAIL reset_scan8 cyc=%0d got %h/%b want %h/%b", cyc, anode8, ssd8, exp_an(8, cyc), exp_ssd(8, cyc));
      end
    end
  endtask

  task automatic test_load_1234();
    blank_en = 1'b1;
    pulse_load(1234);
    for (int k = 0; k < 17; k++) begin
      checks++;
      if (busy8 !== 1'b1) begin
        fails++;
        $display("FAIL busy_high k=%0d got %b want 1", k, busy8);
      end
      @(negedge clk);
    end
    checks++;
    if (busy8 !== 1'b0 || busy4 !== 1'b0) begin
      fails++;
      $display("FAIL busy_low got %b%b want 00", busy8, busy4);
    end
    shown8 = 1234;
    shown4 = 1234;
    for (int k = 0; k < 140; k++) begin
      @(negedge clk);
      checks++;
      if (anode8 !== exp_an(8, cyc) || ssd8 !== exp_ssd(8, cyc) ||
          anode4 !== 4'(exp_an(4, cyc)) || ssd4 !== exp_ssd(4, cyc)) begin
        fails++;
        $display("FAIL disp_1234 cyc=%0d got %h/%b %h/%b want %h/%b %h/%b", cyc, anode8, ssd8, anode4, ssd4,
                 exp_an(8, cyc), exp_ssd(8, cyc), 4'(exp_an(4, cyc)), exp_ssd(4, cyc));
      end
    end
  endtask

  task automatic test_ovf();
    for (int t = 0; t < 2; t++) begin
      blank_en = 1'b0;
      pulse_load(t == 0 ? 12345 : 7);
      for (int k = 0; k < 40 && busy4; k++) @(negedge clk);
      shown8 = (t == 0) ? 12345 : 7;
      shown4 = shown8;
      checks++;
      if (busy4 !== 1'b0 || ovf4 !== (t == 0) || ovf8 !== 1'b0) begin
        fails++;
        $display("FAIL ovf_flag val=%0d got busy=%b ovf4=%b ovf8=%b want 0 %0d 0", shown4, busy4, ovf4, ovf8, t == 0);
      end
      for (int k = 0; k < 70; k++) begin
        @(negedge clk);
        checks++;
        if (anode4 !== 4'(exp_an(4, cyc)) || ssd4 !== exp_ssd(4, cyc)) begin
          fails++;
          $display("FAIL ovf_disp4 val=%0d cyc=%0d got %h/%b want %h/%b", shown4, cyc, anode4, ssd4,
                   4'(exp_an(4, cyc)), exp_ssd(4, cyc));
        end
      end
    end
  endtask

  task automatic test_load_while_busy();
    pulse_load(99);
    value = 16'd5;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 40 && busy8; k++) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0) begin
      fails++;
      $display("FAIL busy_timeout got %b want 0", busy8);
    end
    shown8 = 99;
    shown4 = 99;
    for (int k = 0; k < 140; k++) begin
      @(negedge clk);
      checks++;
      if (anode8 !== exp_an(8, cyc) || ssd8 !== exp_ssd(8, cyc) || busy8 !== 1'b0) begin
        fails++;
        $display("FAIL busy_ignore cyc=%0d got %h/%b busy=%b want %h/%b 0", cyc, anode8, ssd8, busy8,
                 exp_an(8, cyc), exp_ssd(8, cyc));
      end
    end
  endtask

  task automatic test_msg();
    pulse_load(12345);
    for (int k = 0; k < 40 && busy4; k++) @(negedge clk);
    shown8 = 12345;
    shown4 = 12345;
    msg_v = {8'($urandom), 32'($urandom)};
    msg_v[19:0] = {5'd10, 5'd11, 5'd10, 5'd17};
    msg_en = 1'b1;
    blank_en = 1'b1;
    for (int k = 0; k < 140; k++) begin
      @(negedge clk);
      checks++;
      if (anode8 !== exp_an(8, cyc) || ssd8 !== exp_ssd(8, cyc) ||
          anode4 !== 4'(exp_an(4, cyc)) || ssd4 !== exp_ssd(4, cyc)) begin
        fails++;
        $display("FAIL msg_disp cyc=%0d got %h/%b %h/%b want %h/%b %h/%b", cyc, anode8, ssd8, anode4, ssd4,
                 exp_an(8, cyc), exp_ssd(8, cyc), 4'(exp_an(4, cyc)), exp_ssd(4, cyc));
      end
    end
    msg_en = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      blank_en = 1'($urandom_range(0, 1));
      shown8 = int'($urandom_range(0, 65535));
      shown4 = shown8;
      pulse_load(shown8);
      for (int k = 0; k < 40 && busy8; k++) @(negedge clk);
      checks++;
      if (busy8 !== 1'b0 || ovf8 !== 1'b0 || ovf4 !== (shown4 >= 10000)) begin
        fails++;
        $display("FAIL rand_flags val=%0d got busy=%b ovf8=%b ovf4=%b want 0 0 %0d", shown8, busy8, ovf8, ovf4,
                 shown4 >= 10000);
      end
      for (int k = 0; k < 140; k++) begin
        @(negedge clk);
        checks++;
        if (anode8 !== exp_an(8, cyc) || ssd8 !== exp_ssd(8, cyc) ||
            anode4 !== 4'(exp_an(4, cyc)) || ssd4 !== exp_ssd(4, cyc)) begin
          fails++;
          $display("FAIL rand_disp val=%0d cyc=%0d got %h/%b %h/%b want %h/%b %h/%b", shown8, cyc, anode8, ssd8,
                   anode4, ssd4, exp_an(8, cyc), exp_ssd(8, cyc), 4'(exp_an(4, cyc)), exp_ssd(4, cyc));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    pulse_load(12345);
    for (int k = 0; k < 40 && busy4; k++) @(negedge clk);
    checks++;
    if (ovf4 !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_ovf got %b want 1", ovf4);
    end
    blank_en = 1'b1;
    pulse_load(4321);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy8 !== 1'b0 || busy4 !== 1'b0 || ovf4 !== 1'b0 || anode8 !== 8'hFF || ssd8 !== 7'h7F) begin
      fails++;
      $display("FAIL mid_reset got busy=%b%b ovf4=%b an=%h ssd=%b want 00 0 FF 1111111",
               busy8, busy4, ovf4, anode8, ssd8);
    end
    @(negedge clk);
    reset = 1'b0;
    shown8 = 0;
    shown4 = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      checks++;
      if (anode8 !== exp_an(8, cyc) || ssd8 !== exp_ssd(8, cyc) || busy8 !== 1'b0 ||
          anode4 !== 4'(exp_an(4, cyc)) || ssd4 !== exp_ssd(4, cyc)) begin
        fails++;
        $display("FAIL post_reset cyc=%0d got %h/%b %h/%b busy=%b want %h/%b %h/%b 0", cyc, anode8, ssd8, anode4,
                 ssd4, busy8, exp_an(8, cyc), exp_ssd(8, cyc), 4'(exp_an(4, cyc)), exp_ssd(4, cyc));
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_1234();
    test_ovf();
    test_load_while_busy();
    test_msg();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
